fa_step3_norm: RTL and testbench
================================

Name: fa_step3_norm

Overview:
- Final adder stage and normalizer of the FP MAC: consumes the stage-2 registered prefix vectors (P0, P2, G2, GG) plus sign/exponent/flag.
- Completes the Kogge-Stone tree (spans 4, 8, 16) and forms the 25-bit mantissa sum.
- Normalizes, then packs an IEEE-754 single-precision result.
- Two-stage pipeline with valid/ready flow control so the MAC accumulator can stall it.

Parameters:
- MW, 24, mantissa width including hidden bit (tree sized MW+1).
- EW, 8, exponent width.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RESET  input  1  synchronous, active-high reset.
- in_valid  input  1  stage-2 vectors valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- in_sign  input  1  result sign.
- in_ex  input  EW  pre-normalization exponent.
- in_yn  input  1  operation-enable flag; 0 forces result to +0.
- in_P0  input  MW+1  bitwise propagate; bit0 is carry-in slot, always 0.
- in_P2  input  MW+1  span-4 group propagate, bits [MW:4] meaningful.
- in_G2  input  MW+1  span-4 group generate [MW:4]; bits [3:0] are final prefix carries.
- in_GG  input  MW+1  final prefix carries; only [3:0] used.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_result  output  32  packed {sign, exponent[7:0], fraction[22:0]}.
- out_ovf  output  1  exponent overflow; result is infinity.
- out_unf  output  1  exponent underflow; result flushed to zero.

Behaviour:
- Reset: RESET=1 at a clock edge clears both pipeline valids and sets out_result, out_ovf and out_unf to 0. This applies mid-operation and discards in-flight data. in_ready=1 during the first cycle after reset.
- Transfer rules: input accepted when in_valid && in_ready. Output consumed when out_valid && out_ready.
- Latency: 2 cycles from acceptance to out_valid with no stall.
- Stage A (combinational in, registered out):
  - Prefix levels at distances 4, 8, 16 using black cells (G = Gh | Ph&Gl, P = Ph&Pl).
  - Gray cells where the low group reaches bit 0.
  - Result is G[MW:0], the final prefix carries.
  - S[i] = P0[i] ^ G[i-1] for i=1..MW; cout = G[MW]; sum = {cout, S[MW:1]}, 25 bits.
  - Registers sum, sign, ex, yn.
- Stage B: normalize and pack.
  - yn=0: result 0x00000000, ovf=0, unf=0.
  - cout=1: mantissa = sum[24:1], exponent = ex+1.
  - cout=0, sum[23]=1: mantissa = sum[23:0], exponent = ex.
  - cout=0, sum[23]=0: lzc = leading zeros of sum[23:0].
    - sum==0: result +0, unf=0.
    - lzc >= ex (unsigned): result ±0 with sign kept, unf=1.
    - Otherwise shift left by lzc, exponent = ex-lzc.
  - Exponent >= 255 after increment (9-bit compare): result {sign, 0xFF, 0}, ovf=1.
  - Rounding is truncation. The fraction is mantissa[22:0].
- Flow control (skid-free):
  - Stage B holds its registers while out_valid && !out_ready.
  - Stage A advances when stage B is empty or draining.
  - in_ready = !A_valid || !B_valid || out_ready.
- Simultaneous accept and drain in the same cycle keeps full throughput of 1 result per cycle.
- Outputs stay stable while stalled.
- Bubbles propagate; out_result holds its last value when out_valid=0.

Test Plan:
The bench model generates stage-2 vectors from operand mantissas A and B (P0 = {A^B, 0}, span-4 prefix).

- A=B=0x800000, ex=127, sign=0, yn=1, out_ready=1 -> out_result=0x40000000 after 2 cycles, ovf=0.
- A=0xC00000, B=0x800000, ex=127 -> 0x40200000 (2.5).
- A=0x800000, B=0x000001, ex=127 -> 0x3F800001 (no carry, no shift).
- A=0x000000, B=0x400000, ex=127 -> 0x3F000000. Same vector with ex=0 -> 0x00000000, unf=1.
- A=B=0x800000, ex=254, sign=1 -> 0xFF800000, ovf=1. Any vector with yn=0 -> 0x00000000.
- Stall and reset:
  - Stream 4 back-to-back vectors with out_ready=0 for 3 cycles. Required: in_ready drops once both stages are full, out_result is stable, then all 4 results arrive in order with none lost or duplicated.
  - Assert RESET mid-stream. Required: out_valid=0 the next cycle, and no stale result appears after reset.

Source files
------------

// File: rtl/fa_step3_norm.sv
// FP MAC final adder + normalizer: completes the span-4/8/16 prefix tree, forms the sum, normalizes and packs IEEE-754 single.
// Latency: 2 cycles from input acceptance to out_valid (stage A register, stage B register).
// Backpressure: skid-free valid/ready; stage B holds while out_valid && !out_ready, stage A advances when B is empty or draining.
//
// Ports:
//   CLK, RESET                 clock and synchronous active-high reset
//   in_valid / in_ready        input handshake
//   in_sign, in_ex, in_yn      result sign, pre-normalization exponent, operation enable (0 -> +0)
//   in_P0                      bitwise propagate, bit0 is the (always 0) carry-in slot
//   in_P2, in_G2               span-4 group propagate/generate, bits [MW:4]
//   in_GG                      final prefix carries for bits [3:0]
//   out_valid / out_ready      output handshake
//   out_result                 packed {sign, exponent, fraction}
//   out_ovf, out_unf           exponent overflow (infinity) / underflow (flushed to signed zero)
module fa_step3_norm #(
    parameter int MW = 24,
    parameter int EW = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [EW-1:0] in_ex,
    input  logic          in_yn,
    input  logic [MW:0]   in_P0,
    input  logic [MW:0]   in_P2,
    input  logic [MW:0]   in_G2,
    input  logic [MW:0]   in_GG,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_result,
    output logic          out_ovf,
    output logic          out_unf
);

    localparam int LZW = $clog2(MW + 1);

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic a_vld_q;
    logic b_vld_q;
    logic b_adv;

    assign b_adv     = !b_vld_q || out_ready;
    assign in_ready  = !a_vld_q || b_adv;
    assign out_valid = b_vld_q;

    // ------------------------------------------------------------------
    // Stage A: finish the prefix tree and form the 25-bit sum
    // ------------------------------------------------------------------
    logic [MW:0] pf_g, pf_p, pf_gn, pf_pn;
    logic [MW:0] sum_d;

    always_comb begin
        pf_g  = '0;
        pf_p  = '0;
        pf_gn = '0;
        pf_pn = '0;
        // Bits below 4 already carry their final prefix value; their
        // propagate is never consumed since any cell reaching them is gray.
        for (int i = 0; i <= MW; i++) begin
            if (i < 4) begin
                pf_g[i] = in_GG[i];
                pf_p[i] = 1'b0;
            end else begin
                pf_g[i] = in_G2[i];
                pf_p[i] = in_P2[i];
            end
        end
        for (int lvl = 0; lvl < 3; lvl++) begin
            pf_gn = pf_g;
            pf_pn = pf_p;
            for (int i = (4 << lvl); i <= MW; i++) begin
                pf_gn[i] = pf_g[i] | (pf_p[i] & pf_g[i-(4<<lvl)]);
                pf_pn[i] = pf_p[i] & pf_p[i-(4<<lvl)];
            end
            pf_g = pf_gn;
            pf_p = pf_pn;
        end
    end

    always_comb begin
        sum_d     = '0;
        sum_d[MW] = pf_g[MW];
        for (int i = 1; i <= MW; i++) begin
            sum_d[i-1] = in_P0[i] ^ pf_g[i-1];
        end
    end

    logic [MW:0]   a_sum_q;
    logic          a_sign_q;
    logic [EW-1:0] a_ex_q;
    logic          a_yn_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_vld_q <= 1'b0;
        end else if (in_ready) begin
            a_vld_q <= in_valid;
        end
    end

    // Payload needs no reset: it is only observed behind a_vld_q.
    always_ff @(posedge CLK) begin
        if (in_valid && in_ready) begin
            a_sum_q  <= sum_d;
            a_sign_q <= in_sign;
            a_ex_q   <= in_ex;
            a_yn_q   <= in_yn;
        end
    end

    // ------------------------------------------------------------------
    // Stage B: normalize and pack
    // ------------------------------------------------------------------
    logic [LZW-1:0] lzc;
    logic [MW-1:0]  mant;
    logic [EW:0]    exp_w;
    logic           norm;
    logic [31:0]    res_d;
    logic           ovf_d;
    logic           unf_d;

    always_comb begin
        lzc = LZW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (a_sum_q[i]) begin
                lzc = LZW'(MW - 1 - i);
            end
        end
    end

    always_comb begin
        mant  = '0;
        exp_w = '0;
        norm  = 1'b0;
        res_d = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (!a_yn_q) begin
            res_d = '0;
        end else if (a_sum_q[MW]) begin
            mant  = a_sum_q[MW:1];
            exp_w = {1'b0, a_ex_q} + {{EW{1'b0}}, 1'b1};
            norm  = 1'b1;
        end else if (a_sum_q[MW-1]) begin
            mant  = a_sum_q[MW-1:0];
            exp_w = {1'b0, a_ex_q};
            norm  = 1'b1;
        end else if (a_sum_q[MW-1:0] == '0) begin
            res_d = '0;
        end else if ({{(EW-LZW){1'b0}}, lzc} >= a_ex_q) begin
            // Shift would drive the exponent to zero or below: signed zero.
            res_d = {a_sign_q, 31'b0};
            unf_d = 1'b1;
        end else begin
            mant  = a_sum_q[MW-1:0] << lzc;
            exp_w = {1'b0, a_ex_q} - {{(EW+1-LZW){1'b0}}, lzc};
            norm  = 1'b1;
        end

        if (norm) begin
            if (exp_w >= {1'b0, {EW{1'b1}}}) begin
                res_d = {a_sign_q, {EW{1'b1}}, {(31-EW){1'b0}}};
                ovf_d = 1'b1;
            end else begin
                res_d = {a_sign_q, exp_w[EW-1:0], mant[MW-2:0]};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            b_vld_q    <= 1'b0;
            out_result <= '0;
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
        end else if (b_adv) begin
            b_vld_q <= a_vld_q;
            // Bubbles leave the last result visible on the output.
            if (a_vld_q) begin
                out_result <= res_d;
                out_ovf    <= ovf_d;
                out_unf    <= unf_d;
            end
        end
    end

    // Inputs bits that carry no information for this stage.
    logic unused_bits;
    assign unused_bits = ^{in_P0[0], in_P2[3:0], in_G2[3:0], in_GG[MW:4], mant[MW-1]};

endmodule

// File: tb/tb_fa_step3_norm.sv
module tb_fa_step3_norm;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_ex;
    logic        in_yn;
    logic [24:0] in_P0, in_P2, in_G2, in_GG;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_unf;

    always #5 CLK = ~CLK;

    fa_step3_norm #(.MW(24), .EW(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_ex(in_ex), .in_yn(in_yn),
        .in_P0(in_P0), .in_P2(in_P2), .in_G2(in_G2), .in_GG(in_GG),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf)
    );

    int tests = 0;
    int fails = 0;
    int delivered = 0;
    logic [23:0] cur_a, cur_b;
    logic [33:0] q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: real addition of the two mantissas, then normalization by
    // repeated shifting. Returns {ovf, unf, result}.
    function automatic logic [33:0] model(input logic [23:0] a, input logic [23:0] b,
                                          input logic [7:0] ex, input logic sg, input logic yn);
        int s, e, lz;
        logic [31:0] r;
        s  = int'(a) + int'(b);
        if (!yn || s == 0) return 34'd0;
        e  = int'(ex);
        lz = 0;
        if (s >= (1 << 24)) begin
            s = s >> 1;
            e = e + 1;
        end else begin
            while (s < (1 << 23)) begin
                s  = s << 1;
                lz = lz + 1;
                e  = e - 1;
            end
        end
        if (lz > 0 && lz >= int'(ex)) return {2'b01, sg, 31'b0};
        if (e >= 255) return {2'b10, sg, 8'hFF, 23'b0};
        r = {sg, e[7:0], s[22:0]};
        return {2'b00, r};
    endfunction

    // Builds the stage-2 vectors (bitwise P0, span-4 prefix) from two mantissas.
    task automatic drive_vec(input logic [23:0] a, input logic [23:0] b,
                             input logic [7:0] ex, input logic sg, input logic yn);
        logic [24:0] pb, gb, p2, g2;
        logic        gg, pp;
        logic [20:0] junk;
        pb = {a ^ b, 1'b0};
        gb = {a & b, 1'b0};
        for (int i = 0; i <= 24; i++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int k = (i >= 3 ? i - 3 : 0); k <= i; k++) begin
                gg = gb[k] | (pb[k] & gg);
                pp = pp & pb[k];
            end
            g2[i] = gg;
            p2[i] = pp;
        end
        junk    = 21'($urandom);
        in_P0   = pb;
        in_P2   = p2;
        in_G2   = g2;
        in_GG   = {junk, g2[3:0]};
        in_ex   = ex;
        in_sign = sg;
        in_yn   = yn;
        cur_a   = a;
        cur_b   = b;
    endtask

    task automatic drive_rand();
        logic [23:0] a, b;
        logic [7:0]  ex;
        case ($urandom_range(0, 3))
            0: begin a = 24'($urandom) | 24'h800000; b = 24'($urandom) | 24'h800000; end
            1: begin a = 24'($urandom) >> $urandom_range(0, 23); b = 24'($urandom) >> $urandom_range(0, 23); end
            2: begin a = 24'($urandom); b = 24'($urandom) >> $urandom_range(0, 8); end
            default: begin a = 24'($urandom) >> $urandom_range(0, 23); b = '0; end
        endcase
        case ($urandom_range(0, 5))
            0: ex = 8'd0;
            1: ex = 8'd1;
            2: ex = 8'd254;
            3: ex = 8'd255;
            default: ex = 8'($urandom_range(1, 254));
        endcase
        drive_vec(a, b, ex, 1'($urandom), $urandom_range(0, 7) != 0);
    endtask

    // Compare process: occupancy-based ready check, stall stability, in-order results.
    logic        prev_stall = 1'b0;
    logic [34:0] prev_out;
    always @(negedge CLK) begin
        if (RESET) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", in_ready, (q.size() < 2) || out_ready);
            if (prev_stall)
                chk("stall_hold", {out_valid, out_ovf, out_unf, out_result}, prev_out);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("stale_valid", out_valid, 1'b0);
                end else if (out_ready) begin
                    chk("result", {out_ovf, out_unf, out_result}, q.pop_front());
                    delivered++;
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(cur_a, cur_b, in_ex, in_sign, in_yn));
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_valid, out_ovf, out_unf, out_result};
        end
    end

    task automatic run_dir(input string name, input logic [23:0] a, input logic [23:0] b,
                           input logic [7:0] ex, input logic sg, input logic yn,
                           input logic [31:0] exp_res, input logic exp_ovf, input logic exp_unf);
        int  lat;
        logic got;
        @(posedge CLK); #1;
        out_ready = 1'b1;
        drive_vec(a, b, ex, sg, yn);
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 6 && !got; c++) begin
            @(negedge CLK);
            if (out_valid) begin
                got = 1'b1;
                lat = c;
            end
        end
        chk({name, "_latency"}, lat, 2);
        chk(name, {out_ovf, out_unf, out_result}, {exp_ovf, exp_unf, exp_res});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc, saw_block, stale;
        int   idx, d0;
        logic [23:0] sa[4], sb[4];

        RESET = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive_vec(24'h0, 24'h0, 8'd0, 1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_outputs", {out_ovf, out_unf, out_result}, 34'd0);

        // Hand-computed points.
        run_dir("two",       24'h800000, 24'h800000, 8'd127, 1'b0, 1'b1, 32'h40000000, 1'b0, 1'b0);
        run_dir("two_five",  24'hC00000, 24'h800000, 8'd127, 1'b0, 1'b1, 32'h40200000, 1'b0, 1'b0);
        run_dir("no_shift",  24'h800000, 24'h000001, 8'd127, 1'b0, 1'b1, 32'h3F800001, 1'b0, 1'b0);
        run_dir("half",      24'h000000, 24'h400000, 8'd127, 1'b0, 1'b1, 32'h3F000000, 1'b0, 1'b0);
        run_dir("unf_ex0",   24'h000000, 24'h400000, 8'd0,   1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1);
        run_dir("ovf",       24'h800000, 24'h800000, 8'd254, 1'b1, 1'b1, 32'hFF800000, 1'b1, 1'b0);
        run_dir("yn_off",    24'hC00000, 24'h800000, 8'd127, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0);
        run_dir("zero_sum",  24'h000000, 24'h000000, 8'd127, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b0);
        run_dir("unf_sign",  24'h000000, 24'h000001, 8'd5,   1'b1, 1'b1, 32'h80000000, 1'b0, 1'b1);
        run_dir("big_shift", 24'h000000, 24'h000003, 8'd100, 1'b0, 1'b1, 32'h27400000, 1'b0, 1'b0);

        // Stall: 4 back-to-back vectors with out_ready low for 3 cycles.
        for (int i = 0; i < 4; i++) begin
            sa[i] = 24'($urandom) | 24'h800000;
            sb[i] = 24'($urandom);
        end
        @(posedge CLK); #1;
        d0 = delivered;
        saw_block = 1'b0;
        out_ready = 1'b0;
        idx = 0;
        drive_vec(sa[0], sb[0], 8'd120, 1'b0, 1'b1);
        in_valid = 1'b1;
        fork
            begin
                for (int g = 0; g < 40 && idx < 4; g++) begin
                    @(negedge CLK);
                    acc = in_ready;
                    if (!acc) saw_block = 1'b1;
                    @(posedge CLK); #1;
                    if (acc) begin
                        idx++;
                        if (idx < 4) drive_vec(sa[idx], sb[idx], 8'(120 + idx), 1'(idx), 1'b1);
                    end
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge CLK);
                #1 out_ready = 1'b1;
            end
        join
        for (int c = 0; c < 20 && q.size() != 0; c++) @(negedge CLK);
        chk("stall_in_ready_dropped", saw_block, 1'b1);
        chk("stall_all_accepted", idx, 4);
        chk("stall_delivered", delivered - d0, 4);

        // Randomized traffic with random backpressure.
        @(posedge CLK); #1;
        acc = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || acc) begin
                drive_rand();
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
            acc = in_valid && in_ready;
            @(posedge CLK); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) @(negedge CLK);
        chk("random_drain_empty", q.size(), 0);

        // Reset mid-stream with both stages occupied.
        @(posedge CLK); #1;
        out_ready = 1'b0;
        drive_rand();
        in_yn    = 1'b1;
        in_valid = 1'b1;
        repeat (2) begin
            @(posedge CLK); #1;
            drive_rand();
        end
        in_valid = 1'b0;
        RESET    = 1'b1;
        @(posedge CLK); #1;
        RESET     = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        chk("midreset_out_valid", out_valid, 1'b0);
        chk("midreset_in_ready", in_ready, 1'b1);
        chk("midreset_outputs", {out_ovf, out_unf, out_result}, 34'd0);
        stale = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            if (out_valid) stale = 1'b1;
        end
        chk("midreset_no_stale", stale, 1'b0);

        // Pipeline still works after the reset.
        run_dir("post_reset", 24'hC00000, 24'h800000, 8'd127, 1'b0, 1'b1, 32'h40200000, 1'b0, 1'b0);

        @(posedge CLK); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
